// File: rtl/audio_codec_serdes.sv
// WM8731 I2S serial front-end (codec is master): ADCDAT -> stereo frame FIFO, and
// stereo frame FIFO -> DACDAT. All codec pins are oversampled on clk_clk.
module audio_codec_serdes #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic                      codec_bclk,
  input  logic                      codec_adclrck,
  input  logic                      codec_adcdat,
  input  logic                      codec_daclrck,
  output logic                      codec_dacdat,
  output logic [2*DATA_WIDTH-1:0]   adc_data,
  output logic                      adc_valid,
  input  logic                      adc_ready,
  input  logic [2*DATA_WIDTH-1:0]   dac_data,
  input  logic                      dac_valid,
  output logic                      dac_ready,
  output logic                      adc_overrun,
  output logic                      dac_underrun,
  input  logic                      clear_flags
);

  localparam int unsigned FW = 2 * DATA_WIDTH;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] W_LEN  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] W_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] DEPTH  = LW'(FIFO_DEPTH);

  // Synchronizers, bit order {adcdat, daclrck, adclrck, bclk}
  logic [3:0] r_sync1, r_sync2;
  logic       r_bclk_prev, r_adc_lrck_prev, r_dac_lrck_prev;
  logic       w_bclk, w_adclrck, w_daclrck, w_adcdat;
  logic       w_rise, w_fall, w_adc_chg, w_dac_chg;

  assign w_bclk    = r_sync2[0];
  assign w_adclrck = r_sync2[1];
  assign w_daclrck = r_sync2[2];
  assign w_adcdat  = r_sync2[3];
  assign w_rise    = w_bclk & ~r_bclk_prev;
  assign w_fall    = ~w_bclk & r_bclk_prev;
  assign w_adc_chg = w_rise & (w_adclrck != r_adc_lrck_prev);
  assign w_dac_chg = w_fall & (w_daclrck != r_dac_lrck_prev);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1         <= '0;
      r_sync2         <= '0;
      r_bclk_prev     <= 1'b0;
      r_adc_lrck_prev <= 1'b0;
      r_dac_lrck_prev <= 1'b0;
    end else begin
      r_sync1     <= {codec_adcdat, codec_daclrck, codec_adclrck, codec_bclk};
      r_sync2     <= r_sync1;
      r_bclk_prev <= w_bclk;
      if (w_rise) r_adc_lrck_prev <= w_adclrck;
      if (w_fall) r_dac_lrck_prev <= w_daclrck;
    end
  end

  // ADC deserializer. r_adc_sync: an LRCK edge has been seen; r_adc_armed: a left half
  // has started, so a right word may complete a frame.
  logic                  r_adc_sync, r_adc_armed, r_adc_ch;
  logic [CW-1:0]         r_adc_bitcnt;
  logic [DATA_WIDTH-1:0] r_adc_word, r_adc_left, w_adc_align;
  logic                  w_adc_active, w_adc_push;
  logic [FW-1:0]         w_adc_frame;

  assign w_adc_active = r_adc_bitcnt < W_LEN;
  // Left-justify a partially captured word so missing LSBs read as zero
  assign w_adc_align  = r_adc_word << (W_LEN - r_adc_bitcnt);

  always_comb begin
    w_adc_push  = 1'b0;
    w_adc_frame = {r_adc_left, w_adc_align};
    if (w_adc_chg) begin
      w_adc_push = r_adc_sync & r_adc_armed & r_adc_ch & w_adc_active;
    end else if (w_rise && r_adc_sync && r_adc_ch && r_adc_bitcnt == W_LAST) begin
      w_adc_push  = r_adc_armed;
      w_adc_frame = {r_adc_left, r_adc_word[DATA_WIDTH-2:0], w_adcdat};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_adc_sync   <= 1'b0;
      r_adc_armed  <= 1'b0;
      r_adc_ch     <= 1'b0;
      r_adc_bitcnt <= '0;
      r_adc_word   <= '0;
      r_adc_left   <= '0;
    end else if (w_adc_chg) begin
      r_adc_sync   <= 1'b1;
      r_adc_ch     <= w_adclrck;
      r_adc_bitcnt <= '0;
      r_adc_word   <= '0;
      if (w_adclrck) r_adc_left  <= w_adc_align;
      else           r_adc_armed <= 1'b1;
    end else if (w_rise && r_adc_sync && w_adc_active) begin
      r_adc_word   <= {r_adc_word[DATA_WIDTH-2:0], w_adcdat};
      r_adc_bitcnt <= r_adc_bitcnt + CW'(1);
    end
  end

  // ADC FIFO, show-ahead
  logic [FW-1:0] r_adc_mem [FIFO_DEPTH];
  logic [AW-1:0] r_adc_wptr, r_adc_rptr;
  logic [LW-1:0] r_adc_cnt, w_adc_cnt_d;
  logic          r_adc_valid, r_adc_overrun;
  logic          w_adc_pop, w_adc_full, w_adc_wr, w_adc_drop;

  assign w_adc_pop   = r_adc_valid & adc_ready;
  assign w_adc_full  = (r_adc_cnt == DEPTH);
  assign w_adc_wr    = w_adc_push & (~w_adc_full | w_adc_pop);
  assign w_adc_drop  = w_adc_push & ~w_adc_wr;
  assign w_adc_cnt_d = r_adc_cnt + LW'(w_adc_wr) - LW'(w_adc_pop);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_adc_mem[i] <= '0;
      r_adc_wptr    <= '0;
      r_adc_rptr    <= '0;
      r_adc_cnt     <= '0;
      r_adc_valid   <= 1'b0;
      r_adc_overrun <= 1'b0;
    end else begin
      if (w_adc_wr) begin
        r_adc_mem[r_adc_wptr] <= w_adc_frame;
        r_adc_wptr            <= r_adc_wptr + AW'(1);
      end
      if (w_adc_pop) r_adc_rptr <= r_adc_rptr + AW'(1);
      r_adc_cnt     <= w_adc_cnt_d;
      r_adc_valid   <= (w_adc_cnt_d != '0);
      r_adc_overrun <= w_adc_drop | (r_adc_overrun & ~clear_flags);
    end
  end

  assign adc_data    = r_adc_mem[r_adc_rptr];
  assign adc_valid   = r_adc_valid;
  assign adc_overrun = r_adc_overrun;

  // DAC FIFO
  logic [FW-1:0] r_dac_mem [FIFO_DEPTH];
  logic [AW-1:0] r_dac_wptr, r_dac_rptr;
  logic [LW-1:0] r_dac_cnt, w_dac_cnt_d;
  logic          r_dac_ready, r_dac_underrun;
  logic          w_dac_push, w_dac_pop, w_dac_empty, w_dac_lfall;
  logic [FW-1:0] w_dac_head;

  assign w_dac_lfall = w_dac_chg & ~w_daclrck;
  assign w_dac_empty = (r_dac_cnt == '0);
  assign w_dac_push  = dac_valid & r_dac_ready;
  assign w_dac_pop   = w_dac_lfall & ~w_dac_empty;
  assign w_dac_head  = r_dac_mem[r_dac_rptr];
  assign w_dac_cnt_d = r_dac_cnt + LW'(w_dac_push) - LW'(w_dac_pop);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_dac_mem[i] <= '0;
      r_dac_wptr     <= '0;
      r_dac_rptr     <= '0;
      r_dac_cnt      <= '0;
      r_dac_ready    <= 1'b0;
      r_dac_underrun <= 1'b0;
    end else begin
      if (w_dac_push) begin
        r_dac_mem[r_dac_wptr] <= dac_data;
        r_dac_wptr            <= r_dac_wptr + AW'(1);
      end
      if (w_dac_pop) r_dac_rptr <= r_dac_rptr + AW'(1);
      r_dac_cnt      <= w_dac_cnt_d;
      r_dac_ready    <= (w_dac_cnt_d != DEPTH);
      r_dac_underrun <= (w_dac_lfall & w_dac_empty) | (r_dac_underrun & ~clear_flags);
    end
  end

  assign dac_ready    = r_dac_ready;
  assign dac_underrun = r_dac_underrun;

  // DAC serializer: delay bit on the LRCK-change fall, then MSB..LSB, then zeros
  logic [DATA_WIDTH-1:0] r_dac_shift, r_dac_right;
  logic [CW-1:0]         r_dac_bitcnt;
  logic                  r_dacdat;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dac_shift  <= '0;
      r_dac_right  <= '0;
      r_dac_bitcnt <= '0;
      r_dacdat     <= 1'b0;
    end else if (w_dac_chg) begin
      r_dacdat     <= 1'b0;
      r_dac_bitcnt <= '0;
      if (w_daclrck) begin
        r_dac_shift <= r_dac_right;
      end else if (!w_dac_empty) begin
        r_dac_shift <= w_dac_head[FW-1:DATA_WIDTH];
        r_dac_right <= w_dac_head[DATA_WIDTH-1:0];
      end else begin
        r_dac_shift <= '0;
        r_dac_right <= '0;
      end
    end else if (w_fall) begin
      if (r_dac_bitcnt < W_LEN) begin
        r_dacdat     <= r_dac_shift[DATA_WIDTH-1];
        r_dac_shift  <= {r_dac_shift[DATA_WIDTH-2:0], 1'b0};
        r_dac_bitcnt <= r_dac_bitcnt + CW'(1);
      end else begin
        r_dacdat <= 1'b0;
      end
    end
  end

  assign codec_dacdat = r_dacdat;

endmodule

// File: doc/audio_codec_serdes.md
Name: audio_codec_serdes

Overview:
- Serial front-end between the WM8731 codec pins and FPGA-side sample streams, running in I2S mode with the codec as master.
- ADC side: deserializes ADCDAT into stereo frames and buffers them in a FIFO for the streaming consumer.
- DAC side: buffers stereo frames from the streaming producer and serializes them onto DACDAT.
- All codec signals (BCLK, ADCLRCK, DACLRCK, ADCDAT) are oversampled in the system clock domain.

Parameters:
- DATA_WIDTH, 24, bits per channel word (16..32).
- FIFO_DEPTH, 8, stereo frames per direction; power of two, >= 2.

Ports:
- clk_clk  in  1  system clock; must be >= 8x BCLK.
- reset_reset_n  in  1  asynchronous active-low reset.
- codec_bclk  in  1  codec bit clock.
- codec_adclrck  in  1  ADC word clock; low = left.
- codec_adcdat  in  1  ADC serial data.
- codec_daclrck  in  1  DAC word clock; low = left.
- codec_dacdat  out  1  DAC serial data, registered.
- adc_data  out  2*DATA_WIDTH  {left,right} frame.
- adc_valid  out  1  FIFO not empty.
- adc_ready  in  1  consumer accepts the frame.
- dac_data  in  2*DATA_WIDTH  {left,right} frame.
- dac_valid  in  1  producer offers a frame.
- dac_ready  out  1  DAC FIFO not full.
- adc_overrun  out  1  sticky: ADC frame dropped.
- dac_underrun  out  1  sticky: DAC frame missing.
- clear_flags  in  1  one-cycle pulse clearing both sticky flags.

Behaviour:
- Clock and reset: one clock (clk_clk); reset_reset_n is asynchronous, active-low.
- Reset values: all outputs 0, both FIFOs empty, shift registers and bit counters 0, synchronizer and previous-value registers 0.
- Synchronization: BCLK, ADCLRCK, DACLRCK and ADCDAT each pass through a 2-flop synchronizer. Rise and fall strobes are derived from the synced BCLK against its previous value. LRCK change is detected by comparing the synced LRCK against its value at the previous BCLK edge of the same type.
- ADC bit counter: on a BCLK rise where ADCLRCK has changed, set channel = LRCK and bitcnt = 0. The first rise after a change is the I2S delay bit and is discarded.
- ADC capture: the next DATA_WIDTH rises shift ADCDAT into the channel word, MSB first; later rises are ignored.
- ADC short half-frame: if LRCK changes before DATA_WIDTH bits are captured, the remaining LSBs are 0.
- ADC frame push: when the right word completes, or on the LRCK change that ends a short right half, push {left,right} to the ADC FIFO.
- ADC full FIFO: the push is accepted only if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the frame is dropped and adc_overrun is set.
- ADC output: adc_data shows the FIFO head (show-ahead); a pop occurs when adc_valid && adc_ready.
- DAC input: a push occurs when dac_valid && dac_ready; the FIFO holds FIFO_DEPTH frames.
- DAC load: on a BCLK fall where DACLRCK has changed:
  - LRCK falling (start of left): pop one frame if available and latch the right word. If the FIFO is empty, load zeros for both channels and set dac_underrun.
  - LRCK rising: load the latched right word.
  - In both cases codec_dacdat drives 0 on this fall (delay bit).
- DAC shift-out: the next DATA_WIDTH falls drive MSB..LSB; later falls drive 0.
- DAC output timing: codec_dacdat updates <= 3 clk_clk after the BCLK fall, well before the next rise.
- Flags: a set event in the same cycle as clear_flags wins, so the flag stays 1.
- Reset mid-operation: the async reset clears all state immediately. After release:
  - ADC ignores bits until the first LRCK change.
  - DAC drives 0 until the first DACLRCK falling edge.
  - The first DACLRCK fall with an empty FIFO sets dac_underrun.

Test Plan:
- ADC path: DATA_WIDTH=24, I2S codec model sends left 0xA5A5A5, right 0x5A5A5A with adc_ready=1 -> adc_valid rises after the right LSB with adc_data=0xA5A5A55A5A5A; adc_overrun=0.
- DAC path: push frame 0x800001_7FFFFF, run two LRCK periods -> DACDAT sampled on BCLK rises yields the delay bit then 0x800001 in the left half; delay bit then 0x7FFFFF in the right half; dac_underrun=0.
- Underrun: DAC FIFO empty at a DACLRCK fall -> 48 data bits all 0, dac_underrun=1 and held; clear_flags pulse -> 0. clear_flags coincident with the next underrun -> stays 1.
- Overrun: adc_ready=0 for 9 frames (DEPTH 8) -> adc_overrun=1; the 8 oldest frames drain in order; the 9th frame is absent.
- Simultaneous full push/pop: ADC FIFO full, adc_ready=1 in the exact push cycle -> no overrun, level stays 8. DAC: dac_valid held with FIFO full -> dac_ready=0 and no frame lost.
- Reset mid-frame: assert reset_reset_n=0 mid-left-word -> all outputs 0 immediately. After release, the partial frame is not pushed; the next full frame 0x123456_654321 appears correctly.
